// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first.
// Shifts one word out on MOSI while assembling one word from MISO, framed by CS.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t                  state_q;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0]   tx_q, rx_q, rxd_q;
  logic                    sclk_q, cs_q, mosi_q, busy_q, done_q;
  logic                    div_end, last_bit;

  assign div_end  = (div_q == DIV_LAST);
  assign last_bit = (bitcnt_q == BIT_LAST);
  // Both counters return to zero at their terminal count instead of wrapping.
  assign div_d    = div_end ? '0 : div_q + 1'b1;
  assign bitcnt_d = last_bit ? '0 : bitcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rxd_q    <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q     <= masterDataToSend;
            mosi_q   <= masterDataToSend[DATA_WIDTH-1];
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
            div_q    <= '0;
            bitcnt_q <= '0;
            state_q  <= LEAD;
          end
        end
        LEAD: begin
          div_q <= div_d;
          if (div_end) state_q <= XFER;
        end
        XFER: begin
          div_q <= div_d;
          if (div_end) begin
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_q <= {rx_q[DATA_WIDTH-2:0], MISO};
            end else begin
              // MOSI only moves on the falling toggle, so it is stable at every rising edge.
              bitcnt_q <= bitcnt_d;
              if (last_bit) begin
                state_q <= TRAIL;
              end else begin
                tx_q   <= tx_q << 1;
                mosi_q <= tx_q[DATA_WIDTH-2];
              end
            end
          end
        end
        TRAIL: begin
          div_q <= div_d;
          if (div_end) begin
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            rxd_q   <= rx_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign masterDataReceived = rxd_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign SCLK               = sclk_q;
  assign CS                 = cs_q;
  assign MOSI               = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: CLK_DIV=2 instance (loopback or slave model)
// and a CLK_DIV=1 loopback instance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_busy, a_done, a_sclk, a_cs, a_mosi, a_miso;
  logic [7:0] a_tx, a_rx;
  logic       b_start, b_busy, b_done, b_sclk, b_cs, b_mosi, b_miso;
  logic [7:0] b_tx, b_rx;

  logic       use_slave, seq_chk;
  logic [7:0] slv_tx, slv_rx;
  int         slv_idx = 0;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset(rst_n), .start(a_start), .masterDataToSend(a_tx),
    .masterDataReceived(a_rx), .busy(a_busy), .done(a_done),
    .SCLK(a_sclk), .CS(a_cs), .MOSI(a_mosi), .MISO(a_miso));

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(rst_n), .start(b_start), .masterDataToSend(b_tx),
    .masterDataReceived(b_rx), .busy(b_busy), .done(b_done),
    .SCLK(b_sclk), .CS(b_cs), .MOSI(b_mosi), .MISO(b_miso));

  // Mode-0 slave: drives its current bit, advances on SCLK fall, captures MOSI on SCLK rise.
  always @(negedge a_sclk or posedge a_cs)
    if (a_cs) slv_idx <= 0;
    else      slv_idx <= slv_idx + 1;
  always @(posedge a_sclk) slv_rx <= {slv_rx[6:0], a_mosi};

  assign a_miso = use_slave ? ((slv_idx < 8) ? slv_tx[3'(7 - slv_idx)] : 1'b0) : a_mosi;
  assign b_miso = b_mosi;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit         inst;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input bit inst, input logic [7:0] d, input int c);
    exp_t e;
    e.inst = inst; e.data = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic got_done(input bit inst, input logic [7:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_done: inst %0d got %0h with nothing expected (cycle %0d)", inst, d, cyc);
    end else begin
      e = sbq.pop_front();
      check("done_inst", 32'(inst), 32'(e.inst));
      check("rx_data", 32'(d), 32'(e.data));
      check("done_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: scoreboard pops on done plus protocol observations on instance A.
  logic a_done_p = 1'b0, b_done_p = 1'b0, a_sclk_p = 1'b0, a_cs_p = 1'b1, a_mosi_p = 1'b0;
  int   rises = 0, mviol = 0, cs_run = 0;

  always @(negedge clk) begin
    if (a_done) begin
      check("a_done_one_cycle", 32'(a_done_p), 32'd0);
      got_done(1'b0, a_rx);
    end
    if (b_done) begin
      check("b_done_one_cycle", 32'(b_done_p), 32'd0);
      got_done(1'b1, b_rx);
    end
    if (a_sclk === 1'b1 && a_sclk_p === 1'b0 && a_cs === 1'b0) rises <= rises + 1;
    if (a_sclk === 1'b1 && a_sclk_p === 1'b1 && a_mosi !== a_mosi_p) mviol <= mviol + 1;
    if (a_cs === 1'b0 && a_cs_p === 1'b1 && seq_chk) check("cs_high_gap", cs_run, 1);
    cs_run   <= (a_cs === 1'b1) ? cs_run + 1 : 0;
    a_done_p <= a_done;
    b_done_p <= b_done;
    a_sclk_p <= a_sclk;
    a_cs_p   <= a_cs;
    a_mosi_p <= a_mosi;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_sb();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", sbq.size(), 0);
    if (sbq.size() != 0) sbq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic start_a(input logic [7:0] d, input logic [7:0] exp, input int lat, output int e0);
    a_tx = d;
    a_start = 1'b1;
    e0 = cyc + 1;
    push(1'b0, exp, e0 + lat);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] d, input logic [7:0] exp, input int lat);
    b_tx = d;
    b_start = 1'b1;
    push(1'b1, exp, cyc + 1 + lat);
    @(negedge clk);
    b_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e, r0, mv0, blow;
    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; a_tx = '0; b_tx = '0;
    use_slave = 1'b0; slv_tx = '0; seq_chk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(a_cs), 1);
    check("rst_sclk", 32'(a_sclk), 0);
    check("rst_mosi", 32'(a_mosi), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_rx", 32'(a_rx), 0);
    check("rst_b_cs", 32'(b_cs), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Loopback A5, latency 36, eight SCLK rises inside CS.
    r0 = rises;
    start_a(8'hA5, 8'hA5, 36, e);
    wait_sb();
    check("loop_sclk_rises", rises - r0, 8);

    // Slave returns 3C while master sends C3.
    use_slave = 1'b1;
    slv_tx = 8'h3C;
    mv0 = mviol;
    start_a(8'hC3, 8'h3C, 36, e);
    wait_sb();
    check("slave_captured", 32'(slv_rx), 32'hC3);
    check("mosi_stable_high_sclk", mviol - mv0, 0);
    use_slave = 1'b0;

    // Back-to-back AA, F0, 33 with start held high; data changes mid-transfer ignored.
    a_tx = 8'hAA;
    a_start = 1'b1;
    e = cyc + 1;
    push(1'b0, 8'hAA, e + 36);
    push(1'b0, 8'hF0, e + 73);
    push(1'b0, 8'h33, e + 110);
    wait_cyc(e + 5);   a_tx = 8'h55; seq_chk = 1'b1;
    wait_cyc(e + 36);  a_tx = 8'hF0;
    wait_cyc(e + 40);  a_tx = 8'h0F;
    wait_cyc(e + 73);  a_tx = 8'h33;
    wait_cyc(e + 80);  a_tx = 8'hCC;
    wait_cyc(e + 110); a_start = 1'b0;
    wait_sb();
    seq_chk = 1'b0;

    // Start pulsed during XFER of 5A: no restart, busy held.
    start_a(8'h5A, 8'h5A, 36, e);
    blow = 0;
    while (cyc < e + 35) begin
      if (cyc == e + 10) a_start = 1'b1;
      else               a_start = 1'b0;
      if (a_busy !== 1'b1) blow++;
      @(negedge clk);
    end
    a_start = 1'b0;
    check("busy_held", blow, 0);
    wait_sb();
    repeat (40) @(negedge clk);
    check("busy_after_single_done", 32'(a_busy), 0);

    // Reset during bit 4 of a transfer.
    a_tx = 8'h96;
    a_start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    a_start = 1'b0;
    wait_cyc(e + 19);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs", 32'(a_cs), 1);
    check("midrst_sclk", 32'(a_sclk), 0);
    check("midrst_mosi", 32'(a_mosi), 0);
    check("midrst_busy", 32'(a_busy), 0);
    check("midrst_rx", 32'(a_rx), 0);
    check("midrst_done", 32'(a_done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_a(8'h81, 8'h81, 36, e);
    wait_sb();

    // CLK_DIV=1 instance: FF then 00, latency 18.
    start_b(8'hFF, 8'hFF, 18);
    wait_sb();
    start_b(8'h00, 8'h00, 18);
    wait_sb();

    check("mosi_stable_total", mviol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first; the initiator end for the existing SPI slave.
- Serialises one DATA_WIDTH word onto MOSI while capturing one word from MISO.
- Generates SCLK and CS from the system clock.
- Sits between the host logic (start/busy/done handshake) and one slave.

Parameters:
- DATA_WIDTH, 8, bits per transfer.
- CLK_DIV, 2, system clk cycles per SCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request transfer; sampled only in IDLE.
- masterDataToSend  input  DATA_WIDTH  word to transmit; latched when start is accepted.
- masterDataReceived  output  DATA_WIDTH  last word received; updated at end of transfer.
- busy  output  1  high from the start-accept edge until the done edge.
- done  output  1  one-cycle pulse at end of transfer.
- SCLK  output  1  serial clock; idles low.
- CS  output  1  chip select, active low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset (reset==0 at posedge), taking priority over everything including mid-transfer:
  - state=IDLE, CS=1, SCLK=0, MOSI=0, busy=0, done=0, masterDataReceived=0.
  - Divider, bit counter and shift registers cleared.
- States: IDLE, LEAD, XFER, TRAIL. Divider counter div counts 0..CLK_DIV-1.
- IDLE:
  - CS=1, SCLK=0, MOSI=0, busy=0.
  - start==1 at edge E0: latch masterDataToSend into tx shift register; CS<=0; MOSI<=data[DATA_WIDTH-1]; busy<=1; div<=0; bitcnt<=0; go LEAD.
- LEAD:
  - CS setup, lasting CLK_DIV cycles.
  - At div==CLK_DIV-1: div<=0, go XFER.
  - Otherwise div<=div+1.
- XFER:
  - At each div==CLK_DIV-1: toggle SCLK, div<=0. Total 2*DATA_WIDTH toggles.
  - Rising toggle (SCLK 0->1): shift current MISO into rx register LSB (MSB-first assembly).
  - Falling toggle (SCLK 1->0): bitcnt<=bitcnt+1.
    - Not the last bit: MOSI<=next tx bit.
    - Last bit (bitcnt==DATA_WIDTH-1): MOSI holds; go TRAIL.
- TRAIL:
  - CS hold, lasting CLK_DIV cycles; SCLK stays 0.
  - At div==CLK_DIV-1: CS<=1, MOSI<=0, masterDataReceived<=rx, done<=1, busy<=0, go IDLE.
- Latency: done is high at edge E0 + (2*DATA_WIDTH+2)*CLK_DIV. For defaults that is E0+36.
- done is high exactly one cycle. masterDataReceived holds its value until the next transfer completes or reset.
- start while busy (LEAD/XFER/TRAIL): ignored, no effect.
- start high continuously: a new transfer is accepted on the edge after done, i.e. IDLE lasts 1 cycle minimum.
- masterDataToSend changing mid-transfer: no effect on the transfer in progress.
- MOSI changes only with SCLK low, so it is stable across every SCLK rising edge.
- CLK_DIV=1: SCLK period is 2 clk cycles; all rules unchanged.
- Counters sized ceil(log2) of their range, minimum 1 bit. No wrap beyond the terminal count.

Test Plan:
- Loopback: MISO tied to MOSI, CLK_DIV=2, send 8'hA5.
  - masterDataReceived==8'hA5.
  - done high exactly at E0+36 for one cycle.
  - exactly 8 SCLK rising edges while CS=0.
- Slave model returns 8'h3C while master sends 8'hC3.
  - Slave captures 8'hC3; master reports 8'h3C.
  - MOSI never changes while SCLK=1.
- Sequence 8'hAA, 8'hF0, 8'h33 with start held high throughout.
  - Three done pulses, each one cycle.
  - Received values match in order.
  - CS high for exactly 1 cycle between transfers.
- Pulse start during XFER of transfer 8'h5A.
  - No restart; single done.
  - Result 8'h5A (loopback).
  - busy stays 1 until done.
- Assert reset=0 during bit 4 of a transfer.
  - Same edge: CS=1, SCLK=0, MOSI=0, busy=0, masterDataReceived=0, no done.
  - After release, a new transfer of 8'h81 completes correctly.
- CLK_DIV=1, loopback 8'hFF then 8'h00.
  - Both received correctly.
  - done at E0+18 each time.
